sonuc_tamponu: RTL and testbench
================================

SONUC_TAMPONU -- requirements
Module: sonuc_tamponu

Interface
REQ-001 SHALL have parameter: DERINLIK, default 4, number of result entries; power of two, at least 2.
REQ-002 SHALL have ports, one per line: name, direction, width, meaning.
- clk  input  1  single system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- sonuc  input  64  result word from the calculator top level.
- hazir  input  1  calculator result-ready level.
- gecerli  input  1  calculator result-valid flag.
- tasma  input  1  calculator overflow flag.
- cikis_oku  input  1  consumer pop strobe, sampled on clk.
- cikis_sonuc  output  64  head-entry result.
- cikis_gecerli  output  1  head-entry valid flag.
- cikis_tasma  output  1  head-entry overflow flag.
- cikis_var  output  1  buffer holds at least one entry.
- bos  output  1  buffer empty.
- dolu  output  1  buffer full.
- doluluk  output  $clog2(DERINLIK)+1  current entry count, 0..DERINLIK.
- kayip_sayisi  output  8  count of results dropped because the buffer was full.

Function
REQ-003 SHALL register hazir into hazir_q each clock and define kenar = hazir AND NOT hazir_q.
REQ-004 SHALL capture exactly one entry {sonuc, gecerli, tasma} per kenar; a hazir level held for any number of cycles yields one entry.
REQ-005 SHALL write the entry at the clock edge where kenar is high; the entry SHALL appear on the outputs after that same edge, giving one-clock latency.
REQ-006 SHALL operate as a FIFO with show-ahead: cikis_sonuc, cikis_gecerli and cikis_tasma present the oldest entry while cikis_var=1.
REQ-007 SHALL drive cikis_sonuc, cikis_gecerli and cikis_tasma to 0 while bos=1.
REQ-008 SHALL pop the head entry on a clock edge where cikis_oku=1 and cikis_var=1.
REQ-009 SHALL ignore cikis_oku while bos=1; there is no write-to-read bypass.
REQ-010 SHALL, when empty with kenar=1 and cikis_oku=1 on the same edge, write the entry and ignore the pop, leaving doluluk=1.
REQ-011 SHALL, when full with kenar=1 and cikis_oku=1 on the same edge, perform both the pop and the write; doluluk stays DERINLIK and nothing is dropped.
REQ-012 SHALL, when full with kenar=1 and cikis_oku=0, discard the incoming entry, leave the stored contents unchanged, and count one drop.
REQ-013 SHALL keep its write and read pointers modulo DERINLIK, wrapping with no gap or duplicate entry.
REQ-014 SHALL derive its flags from doluluk: bos = (doluluk==0), dolu = (doluluk==DERINLIK), cikis_var = NOT bos.
REQ-015 SHALL saturate kayip_sayisi at 255.

Reset
REQ-016 SHALL, while rst=0 and without waiting for clk, clear hazir_q, both pointers, doluluk and kayip_sayisi.
REQ-017 SHALL, while rst=0, drive bos=1, dolu=0, cikis_var=0 and all cikis_* data outputs to 0.
REQ-018 SHALL NOT require the storage array to be reset; stale contents SHALL never be visible on the outputs.
REQ-019 SHALL discard all entries held at the time reset is asserted mid-operation.
REQ-020 SHALL, on a clock edge where rst has just deasserted while hazir is already 1, capture that result as a kenar.

Configuration
REQ-021 SHALL, when macro SONUC_KAYIP_SAYAC_EN is defined, implement the drop counter per REQ-012 and REQ-015.
REQ-022 SHALL, when SONUC_KAYIP_SAYAC_EN is undefined, omit the counter logic, keep the kayip_sayisi port, and hold it at 0; the drop behaviour itself is unchanged.

Verification
REQ-023 SHALL cover each directed scenario below; DERINLIK=4 unless noted.
- Reset: assert rst=0 mid-run -> immediately bos=1, dolu=0, doluluk=0, cikis_var=0, cikis_sonuc=0, kayip_sayisi=0.
- Single capture: sonuc=64'h7, gecerli=1, tasma=0, hazir high for 3 cycles -> doluluk=1 after first edge; cikis_sonuc=7, cikis_gecerli=1; no second entry.
- Overflow drop: capture 1,2,3,4 then 5 with no pops -> dolu=1; 5 dropped; kayip_sayisi=1 with macro, 0 without; pops return 1,2,3,4, then bos=1.
- Full simultaneous: buffer holds 1..4; kenar carrying 9 plus cikis_oku on the same edge -> doluluk=4, kayip_sayisi unchanged; pops return 2,3,4,9.
- Empty simultaneous: buffer empty; kenar carrying 64'hFFFF_FFFF_FFFF_FFFF with tasma=1, plus cikis_oku -> doluluk=1, cikis_tasma=1, cikis_sonuc all ones.
- Wrap and saturation: 10 interleaved write/pop pairs -> values returned in order across pointer wrap; 300 drops while full -> kayip_sayisi=255.

Source files
------------

// File: rtl/sonuc_tamponu.sv
// Show-ahead result FIFO that captures one calculator result per rising edge of hazir.
// Optional drop counter is enabled by defining SONUC_KAYIP_SAYAC_EN.
module sonuc_tamponu #(
    parameter int DERINLIK = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [63:0]               sonuc,
    input  logic                      hazir,
    input  logic                      gecerli,
    input  logic                      tasma,
    input  logic                      cikis_oku,
    output logic [63:0]               cikis_sonuc,
    output logic                      cikis_gecerli,
    output logic                      cikis_tasma,
    output logic                      cikis_var,
    output logic                      bos,
    output logic                      dolu,
    output logic [$clog2(DERINLIK):0] doluluk,
    output logic [7:0]                kayip_sayisi
);

    localparam int AW = $clog2(DERINLIK);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PTR_BIR   = 1;
    localparam logic [CW-1:0] SAYI_BIR  = 1;
    localparam logic [CW-1:0] SAYI_DOLU = CW'(DERINLIK);

    typedef struct packed {
        logic [63:0] sonuc;
        logic        gecerli;
        logic        tasma;
    } giris_t;

    giris_t        mem [DERINLIK];
    giris_t        bas;
    logic          hazir_q;
    logic          kenar;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          pop;
    logic          push;

    assign kenar = hazir & ~hazir_q;

    // Consumer handshake: cikis_var acts as valid and cikis_oku as ready; an
    // entry leaves the buffer on a clk edge where both are high. A pop while
    // empty is ignored, and a freshly written entry is never bypassed to the pop.
    assign pop  = cikis_oku & ~bos;
    // A write into a full buffer is only accepted if the same edge frees a slot.
    assign push = kenar & (~dolu | pop);

    assign bos       = (doluluk == '0);
    assign dolu      = (doluluk == SAYI_DOLU);
    assign cikis_var = ~bos;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hazir_q <= 1'b0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            doluluk <= '0;
        end else begin
            hazir_q <= hazir;
            if (push) wr_ptr <= wr_ptr + PTR_BIR;
            if (pop)  rd_ptr <= rd_ptr + PTR_BIR;
            case ({push, pop})
                2'b10:   doluluk <= doluluk + SAYI_BIR;
                2'b01:   doluluk <= doluluk - SAYI_BIR;
                default: doluluk <= doluluk;
            endcase
        end
    end

    // Storage is left unreset; the bos gating below keeps stale words hidden.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{sonuc: sonuc, gecerli: gecerli, tasma: tasma};
    end

    always_comb begin
        bas           = mem[rd_ptr];
        cikis_sonuc   = '0;
        cikis_gecerli = 1'b0;
        cikis_tasma   = 1'b0;
        if (!bos) begin
            cikis_sonuc   = bas.sonuc;
            cikis_gecerli = bas.gecerli;
            cikis_tasma   = bas.tasma;
        end
    end

`ifdef SONUC_KAYIP_SAYAC_EN
    logic kayip;
    assign kayip = kenar & dolu & ~pop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            kayip_sayisi <= 8'd0;
        end else if (kayip && kayip_sayisi != 8'hFF) begin
            kayip_sayisi <= kayip_sayisi + 8'd1;
        end
    end
`else
    assign kayip_sayisi = 8'd0;
`endif

endmodule

// File: tb/tb_sonuc_tamponu.sv
// Directed bench for sonuc_tamponu (DERINLIK=4); expected head entries kept in a queue.
module tb_sonuc_tamponu;

    logic        clk;
    logic        rst;
    logic [63:0] sonuc;
    logic        hazir;
    logic        gecerli;
    logic        tasma;
    logic        cikis_oku;
    logic [63:0] cikis_sonuc;
    logic        cikis_gecerli;
    logic        cikis_tasma;
    logic        cikis_var;
    logic        bos;
    logic        dolu;
    logic [2:0]  doluluk;
    logic [7:0]  kayip_sayisi;

    int total = 0;
    int bad   = 0;
    logic [65:0] exp_q[$];
    logic [7:0]  exp_kayip;

`ifdef SONUC_KAYIP_SAYAC_EN
    localparam bit SAYAC_VAR = 1'b1;
`else
    localparam bit SAYAC_VAR = 1'b0;
`endif

    sonuc_tamponu #(.DERINLIK(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .sonuc        (sonuc),
        .hazir        (hazir),
        .gecerli      (gecerli),
        .tasma        (tasma),
        .cikis_oku    (cikis_oku),
        .cikis_sonuc  (cikis_sonuc),
        .cikis_gecerli(cikis_gecerli),
        .cikis_tasma  (cikis_tasma),
        .cikis_var    (cikis_var),
        .bos          (bos),
        .dolu         (dolu),
        .doluluk      (doluluk),
        .kayip_sayisi (kayip_sayisi)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // one rising edge, returning at the following falling edge
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic capture(input logic [63:0] v, input logic g, input logic t, input bit kabul);
        sonuc   = v;
        gecerli = g;
        tasma   = t;
        hazir   = 1'b1;
        step();
        hazir = 1'b0;
        step();
        if (kabul) exp_q.push_back({v, g, t});
    endtask

    task automatic pop_check(input string tag);
        logic [65:0] e;
        e = exp_q.pop_front();
        chk({tag, "_var"}, 66'(cikis_var), 66'(1));
        chk({tag, "_head"}, {cikis_sonuc, cikis_gecerli, cikis_tasma}, e);
        cikis_oku = 1'b1;
        step();
        cikis_oku = 1'b0;
    endtask

    task automatic chk_empty(input string tag);
        chk({tag, "_bos"}, 66'(bos), 66'(1));
        chk({tag, "_dolu"}, 66'(dolu), 66'(0));
        chk({tag, "_doluluk"}, 66'(doluluk), 66'(0));
        chk({tag, "_var"}, 66'(cikis_var), 66'(0));
        chk({tag, "_cikis"}, {cikis_sonuc, cikis_gecerli, cikis_tasma}, 66'(0));
    endtask

    initial begin
        rst = 1'b0; sonuc = '0; hazir = 1'b0; gecerli = 1'b0; tasma = 1'b0; cikis_oku = 1'b0;
        exp_kayip = 8'd0;
        #1;
        chk_empty("reset0");
        chk("reset0_kayip", 66'(kayip_sayisi), 66'(0));
        @(negedge clk);
        rst = 1'b1;
        step();

        // single capture with hazir held for three edges
        sonuc = 64'h7; gecerli = 1'b1; tasma = 1'b0; hazir = 1'b1;
        step();
        chk("single_doluluk1", 66'(doluluk), 66'(1));
        chk("single_head", {cikis_sonuc, cikis_gecerli, cikis_tasma}, {64'h7, 1'b1, 1'b0});
        step();
        step();
        chk("single_still1", 66'(doluluk), 66'(1));
        hazir = 1'b0;
        step();
        exp_q.push_back({64'h7, 1'b1, 1'b0});
        pop_check("single_pop");
        chk_empty("single_after");

        // overflow drop
        for (int i = 1; i <= 4; i++) capture(64'(i), 1'b1, 1'b0, 1'b1);
        chk("ovf_dolu", 66'(dolu), 66'(1));
        chk("ovf_doluluk", 66'(doluluk), 66'(4));
        capture(64'd5, 1'b1, 1'b0, 1'b0);
        if (SAYAC_VAR) exp_kayip = 8'd1;
        chk("ovf_doluluk_after", 66'(doluluk), 66'(4));
        chk("ovf_kayip", 66'(kayip_sayisi), 66'(exp_kayip));
        for (int i = 0; i < 4; i++) pop_check("ovf_pop");
        chk_empty("ovf_after");

        // full, write and pop on the same edge
        for (int i = 1; i <= 4; i++) capture(64'(i), 1'b0, 1'b1, 1'b1);
        sonuc = 64'd9; gecerli = 1'b1; tasma = 1'b0; hazir = 1'b1; cikis_oku = 1'b1;
        step();
        hazir = 1'b0; cikis_oku = 1'b0;
        void'(exp_q.pop_front());
        exp_q.push_back({64'd9, 1'b1, 1'b0});
        chk("fullsim_doluluk", 66'(doluluk), 66'(4));
        chk("fullsim_kayip", 66'(kayip_sayisi), 66'(exp_kayip));
        step();
        for (int i = 0; i < 4; i++) pop_check("fullsim_pop");
        chk_empty("fullsim_after");

        // empty, write and pop on the same edge: pop ignored
        sonuc = 64'hFFFF_FFFF_FFFF_FFFF; gecerli = 1'b0; tasma = 1'b1; hazir = 1'b1; cikis_oku = 1'b1;
        step();
        hazir = 1'b0; cikis_oku = 1'b0;
        chk("emptysim_doluluk", 66'(doluluk), 66'(1));
        chk("emptysim_tasma", 66'(cikis_tasma), 66'(1));
        chk("emptysim_sonuc", 66'(cikis_sonuc), 66'(64'hFFFF_FFFF_FFFF_FFFF));
        step();
        exp_q.push_back({64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1});
        pop_check("emptysim_pop");
        chk_empty("emptysim_after");

        // interleaved write/pop pairs across pointer wrap
        for (int i = 0; i < 10; i++) begin
            capture(64'h1000 + 64'(i * 3), 1'(i), 1'(i >> 1), 1'b1);
            pop_check("wrap_pop");
        end
        chk_empty("wrap_after");

        // saturation of the drop counter
        for (int i = 0; i < 4; i++) capture(64'hA0 + 64'(i), 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 300; i++) capture(64'hDEAD, 1'b1, 1'b0, 1'b0);
        if (SAYAC_VAR) exp_kayip = 8'd255;
        chk("sat_kayip", 66'(kayip_sayisi), 66'(exp_kayip));
        chk("sat_doluluk", 66'(doluluk), 66'(4));
        chk("sat_head", {cikis_sonuc, cikis_gecerli, cikis_tasma}, exp_q[0]);

        // asynchronous reset mid-operation while full
        #2;
        rst = 1'b0;
        #1;
        exp_q.delete();
        chk_empty("midrst");
        chk("midrst_kayip", 66'(kayip_sayisi), 66'(0));

        // hazir already high when reset releases: captured on the first edge
        @(negedge clk);
        sonuc = 64'h55; gecerli = 1'b1; tasma = 1'b0; hazir = 1'b1;
        step();
        chk("relrst_hold", 66'(doluluk), 66'(0));
        rst = 1'b1;
        step();
        hazir = 1'b0;
        chk("relrst_doluluk", 66'(doluluk), 66'(1));
        step();
        exp_q.push_back({64'h55, 1'b1, 1'b0});
        pop_check("relrst_pop");
        chk_empty("relrst_after");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
